// File: rtl/latch_pipe_skid_pkg.sv
// Shared definitions for the inter-stage pipeline latch: state encoding,
// reset/write-enable polarity constants and the MEM->WB payload layout.
package latch_pipe_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } lps_state_e;

  localparam logic RESET_ENABLE  = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  // MEM->WB payload packing: write-enables sit in the LSBs so they can be masked.
  localparam int WB_WE_LSB   = 0;
  localparam int WB_WE_W     = 3;
  localparam int WB_RD_LSB   = 3;
  localparam int WB_RD_W     = 5;
  localparam int WB_DATA_LSB = 8;
  localparam int WB_DATA_W   = 24;
  localparam int WB_WIDTH    = WB_DATA_LSB + WB_DATA_W;

  function automatic logic [1:0] occupancy_of(input lps_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/latch_payload_reg.sv
// WIDTH-bit payload register with load enable, synchronous clear and
// asynchronous active-low reset, both returning to RST_VAL.
module latch_payload_reg
  import latch_pipe_skid_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      data_q <= RST_VAL;
    end else if (clear_i) begin
      data_q <= RST_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/latch_pipe_skid.sv
// Inter-stage pipeline latch with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and write-enable masking while the stage holds a bubble.
module latch_pipe_skid
  import latch_pipe_skid_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               WE_BITS = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  if (WE_BITS < 0 || WE_BITS > WIDTH) begin : g_bad_we_bits
    $error("latch_pipe_skid: WE_BITS must lie in 0..WIDTH");
  end

  lps_state_e       state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [1:0]       occ_q;
  logic             accept, consume;
  logic             main_load, main_from_skid, skid_load;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = BUSY;
          main_load = 1'b1;
        end
      end
      BUSY: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_d        = BUSY;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything; the payload registers are cleared separately.
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Handshake outputs are registered from the next state, so no path from out_ready reaches in_ready.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occupancy_of(state_d);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // NOTE: payload registers are reset too, so out_data is RST_VAL (never X) straight out of reset.
  latch_payload_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (main_load),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  latch_payload_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (skid_load),
    .d_i     (in_data),
    .q_o     (skid_q)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    if (i < WE_BITS) begin : g_we
      assign out_data[i] = out_valid_q ? main_q[i] : WRITE_DISABLE;
    end else begin : g_payload
      assign out_data[i] = main_q[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_latch_pipe_skid.sv
// Self-checking bench for latch_pipe_skid: table-driven vectors with a queue
// model as scoreboard, plus hand sequences for reset and flush corners.
module tb_latch_pipe_skid;

  localparam int          WIDTH   = 32;
  localparam int          WE_BITS = 3;
  localparam logic [31:0] RST_VAL = 32'h0000_BEE0;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  latch_pipe_skid #(.WIDTH(WIDTH), .WE_BITS(WE_BITS), .RST_VAL(RST_VAL)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic [1:0]  exp_occ;   // occupancy expected after the edge
    logic        chk_rst;   // out_data must equal RST_VAL after the edge
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];       // beats held, head = next to leave
  int          n_tests = 0;
  int          n_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name);
    check({name, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({name, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    check({name, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
    if (mq.size() == 0) check({name, ".we_masked"}, 32'(out_data[2:0]), 32'd0);
  endtask

  // Called at a negedge: drive, score the delivered beat, clock, update model, check.
  task automatic step(input string name, input logic iv, input logic [31:0] id,
                      input logic ordy, input logic fl);
    logic m_acc, m_con;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    m_acc = iv && (mq.size() < 2);
    m_con = (mq.size() > 0) && ordy;
    if (m_con) check({name, ".data"}, out_data, mq[0]);
    @(posedge clock);
    if (fl) begin
      mq.delete();
    end else begin
      if (m_con) void'(mq.pop_front());
      if (m_acc) mq.push_back(id);
    end
    @(negedge clock);
    check_flags(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Stream 1..8 at full throughput, then drain.
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{$sformatf("stream%0d", i), 1'b1, 32'(i), 1'b1, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"stream_drain", 1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0});
    // Back-pressure: A, B held, C refused until downstream frees a slot.
    vecs.push_back('{"bp_a",     1'b1, 32'hA, 1'b0, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"bp_b",     1'b1, 32'hB, 1'b0, 1'b0, 2'd2, 1'b0});
    vecs.push_back('{"bp_c_ref", 1'b1, 32'hC, 1'b0, 1'b0, 2'd2, 1'b0});
    vecs.push_back('{"bp_rel1",  1'b1, 32'hC, 1'b1, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"bp_rel2",  1'b1, 32'hC, 1'b1, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"bp_drain", 1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0});
    // Flush while FULL with no offered beat.
    vecs.push_back('{"fl_full_a", 1'b1, 32'h11, 1'b0, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"fl_full_b", 1'b1, 32'h12, 1'b0, 1'b0, 2'd2, 1'b0});
    vecs.push_back('{"fl_full",   1'b0, 32'h0,  1'b0, 1'b1, 2'd0, 1'b1});
    // Flush while BUSY with a beat offered: that beat must vanish.
    vecs.push_back('{"fl_busy_a", 1'b1, 32'h21, 1'b0, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"fl_busy",   1'b1, 32'h22, 1'b0, 1'b1, 2'd0, 1'b1});
    vecs.push_back('{"fl_after",  1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1});
    // Write-enable masking once a 0x7 beat has drained.
    vecs.push_back('{"we_load",  1'b1, 32'h7, 1'b0, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{"we_drain", 1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0});

    // Reset held with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      check($sformatf("rst%0d.out_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("rst%0d.in_ready", i),  32'(in_ready),  32'd1);
      check($sformatf("rst%0d.occupancy", i), 32'(occupancy), 32'd0);
      check($sformatf("rst%0d.out_data", i),  out_data,       RST_VAL);
    end
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    reset = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].name, vecs[k].iv, vecs[k].id, vecs[k].ordy, vecs[k].fl);
      check({vecs[k].name, ".tbl_occ"}, 32'(occupancy), 32'(vecs[k].exp_occ));
      if (vecs[k].chk_rst) check({vecs[k].name, ".rst_val"}, out_data, RST_VAL);
    end
    check("we_drain.out_data", out_data, 32'h0);

    // Asynchronous reset pulse mid-cycle while FULL.
    step("ar_a", 1'b1, 32'h7, 1'b0, 1'b0);
    step("ar_b", 1'b1, 32'h5, 1'b0, 1'b0);
    check("ar_full.occupancy", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.in_ready",  32'(in_ready),  32'd1);
    check("ar.occupancy", 32'(occupancy), 32'd0);
    check("ar.out_data",  out_data,       RST_VAL);
    mq.delete();
    @(negedge clock);
    reset = 1'b1;
    step("ar_idle",  1'b0, 32'h0,  1'b1, 1'b0);
    step("ar_beat",  1'b1, 32'h33, 1'b0, 1'b0);
    step("ar_drain", 1'b0, 32'h0,  1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
